// File: rtl/calc_sequencer.sv
// calc_sequencer: latches two clipped 7-bit operands and computes add, subtract,
// multiply or a 7-cycle restoring divide, presenting a registered result and format code.
module calc_sequencer (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [17:0] iSW,
  input  logic        iSTART,
  output logic [6:0]  oA,
  output logic [6:0]  oB,
  output logic [13:0] oRESULT,
  output logic [1:0]  oTYPE,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oVALID,
  output logic        oDIVZ
);
  typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [6:0]  a_q, a_d, b_q, b_d, dvd_q, dvd_d, quo_q, quo_d, rem_q, rem_d;
  logic [1:0]  op_q, op_d, type_q, type_d;
  logic [13:0] res_q, res_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, divz_q, divz_d;
  logic [6:0]  a_clip, b_clip, diff_ba, rem_next;
  logic [7:0]  rem_sh;
  logic        q_bit, unused_sw;
  assign unused_sw = ^iSW[3:2];
  assign a_clip    = iSW[17:11] > 7'd99 ? 7'd99 : iSW[17:11];
  assign b_clip    = iSW[10:4] > 7'd99 ? 7'd99 : iSW[10:4];
  assign diff_ba   = b_q - a_q;
  // One restoring step: bring down the next dividend bit, subtract the divisor if it fits.
  assign rem_sh    = {rem_q, dvd_q[6]};
  assign q_bit     = rem_sh >= {1'b0, b_q};
  assign rem_next  = q_bit ? 7'(rem_sh - {1'b0, b_q}) : rem_sh[6:0];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    type_d  = type_q;
    valid_d = valid_q;
    divz_d  = divz_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (iSTART) begin
        a_d     = a_clip;
        b_d     = b_clip;
        op_d    = iSW[1:0];
        valid_d = 1'b0;
        divz_d  = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        state_d = DONE;
        case (op_q)
          2'b00: begin
            res_d  = {7'd0, a_q} + {7'd0, b_q};
            type_d = 2'b00;
          end
          2'b01: begin
            res_d  = a_q >= b_q ? {7'd0, a_q - b_q} : {7'd0, diff_ba};
            type_d = a_q >= b_q ? 2'b00 : (diff_ba > 7'd9 ? 2'b10 : 2'b01);
          end
          2'b10: begin
            res_d  = {7'd0, a_q} * {7'd0, b_q};
            type_d = 2'b00;
          end
          default: if (b_q == 7'd0) begin
            res_d  = 14'd0;
            type_d = 2'b11;
            divz_d = 1'b1;
          end else begin
            dvd_d   = a_q;
            quo_d   = 7'd0;
            rem_d   = 7'd0;
            cnt_d   = 3'd7;
            state_d = DIV;
          end
        endcase
      end
      DIV: begin
        dvd_d = {dvd_q[5:0], 1'b0};
        quo_d = {quo_q[5:0], q_bit};
        rem_d = rem_next;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          res_d   = {quo_q[5:0], q_bit, rem_next};
          type_d  = 2'b11;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
    if (state_d == DONE) valid_d = 1'b1;
  end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      type_q  <= '0;
      valid_q <= 1'b0;
      divz_q  <= 1'b0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      type_q  <= type_d;
      valid_q <= valid_d;
      divz_q  <= divz_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  assign oA      = a_q;
  assign oB      = b_q;
  assign oRESULT = res_q;
  assign oTYPE   = type_q;
  assign oVALID  = valid_q;
  assign oDIVZ   = divz_q;
  assign oBUSY   = state_q == CALC || state_q == DIV;
  assign oDONE   = state_q == DONE;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized and directed checks of calc_sequencer against an
// arithmetic reference model; latency counts the start-accept edge as edge 1.
module tb_calc_sequencer;
  logic        iCLK = 0, iRST = 1, iSTART = 0;
  logic [17:0] iSW = '0;
  logic [6:0]  oA, oB;
  logic [13:0] oRESULT;
  logic [1:0]  oTYPE;
  logic        oBUSY, oDONE, oVALID, oDIVZ;
  int passed = 0, total = 0;

  calc_sequencer dut (
    .iCLK(iCLK), .iRST(iRST), .iSW(iSW), .iSTART(iSTART),
    .oA(oA), .oB(oB), .oRESULT(oRESULT), .oTYPE(oTYPE),
    .oBUSY(oBUSY), .oDONE(oDONE), .oVALID(oVALID), .oDIVZ(oDIVZ)
  );

  always #5 iCLK = ~iCLK;

  function automatic void model(input int ar, br, op, output int res, typ, dz, lat, ca, cb);
    int a, b;
    a = ar > 99 ? 99 : ar;
    b = br > 99 ? 99 : br;
    ca = a; cb = b; dz = 0; lat = 2; typ = 0;
    case (op)
      0: res = a + b;
      1: if (a >= b) res = a - b;
         else begin res = b - a; typ = (b - a) <= 9 ? 1 : 2; end
      2: res = a * b;
      default: begin
        typ = 3;
        if (b == 0) begin res = 0; dz = 1; end
        else begin res = (a / b) * 128 + (a % b); lat = 9; end
      end
    endcase
  endfunction

  task automatic do_op(input int ar, br, op, poke);
    int er, et, ed, el, ea, eb, n, busy;
    model(ar, br, op, er, et, ed, el, ea, eb);
    @(negedge iCLK);
    iSW = {7'(ar), 7'(br), 2'b00, 2'(op)};
    iSTART = 1;
    @(posedge iCLK);
    n = 1; busy = 0;
    @(negedge iCLK);
    iSTART = 0;
    iSW = 18'($urandom);
    while (!oDONE && n < 40) begin
      if (oBUSY) busy++;
      iSTART = (n == poke);
      if (n == poke) iSW = 18'($urandom);
      @(posedge iCLK); n++;
      @(negedge iCLK);
    end
    iSTART = 0;
    total++; if (n !== el) $display("FAIL latency op=%0d a=%0d b=%0d: got %0d want %0d", op, ar, br, n, el); else passed++;
    total++; if (busy !== el - 1) $display("FAIL busy_cycles op=%0d: got %0d want %0d", op, busy, el - 1); else passed++;
    total++; if (oRESULT !== 14'(er)) $display("FAIL result op=%0d a=%0d b=%0d: got %0d want %0d", op, ar, br, oRESULT, er); else passed++;
    total++; if (oTYPE !== 2'(et)) $display("FAIL type op=%0d a=%0d b=%0d: got %0d want %0d", op, ar, br, oTYPE, et); else passed++;
    total++; if ({oDIVZ, oVALID} !== {1'(ed), 1'b1}) $display("FAIL divz_valid op=%0d: got %b%b want %0d1", op, oDIVZ, oVALID, ed); else passed++;
    total++; if ({oA, oB} !== {7'(ea), 7'(eb)}) $display("FAIL operands: got %0d,%0d want %0d,%0d", oA, oB, ea, eb); else passed++;
    @(negedge iCLK);
    total++; if ({oDONE, oBUSY, oVALID, oRESULT} !== {2'b00, 1'b1, 14'(er)}) $display("FAIL hold_after_done: got done=%b busy=%b valid=%b res=%0d want 0 0 1 %0d", oDONE, oBUSY, oVALID, oRESULT, er); else passed++;
  endtask

  task automatic test_reset();
    @(negedge iCLK); @(negedge iCLK);
    total++; if ({oA, oB, oRESULT, oTYPE, oBUSY, oDONE, oVALID, oDIVZ} !== '0) $display("FAIL reset_outputs: got %h want 0", {oA, oB, oRESULT, oTYPE, oBUSY, oDONE, oVALID, oDIVZ}); else passed++;
    iSW = {7'd20, 7'd5, 4'd0};
    iSTART = 1;
    @(negedge iCLK);
    total++; if ({oBUSY, oA} !== 8'd0) $display("FAIL start_in_reset: got busy=%b a=%0d want 0 0", oBUSY, oA); else passed++;
    iRST = 0;
    @(negedge iCLK);
    iSTART = 0;
    total++; if ({oBUSY, oA, oB} !== {1'b1, 7'd20, 7'd5}) $display("FAIL first_start: got busy=%b a=%0d b=%0d want 1 20 5", oBUSY, oA, oB); else passed++;
    repeat (3) @(negedge iCLK);
    total++; if (oRESULT !== 14'd25) $display("FAIL first_result: got %0d want 25", oRESULT); else passed++;
  endtask

  task automatic test_add();
    do_op(99, 99, 0, -1);
    repeat (4) do_op($urandom_range(0, 127), $urandom_range(0, 127), 0, -1);
  endtask

  task automatic test_sub();
    do_op(3, 25, 1, -1);
    do_op(5, 7, 1, -1);
    do_op(40, 40, 1, -1);
    do_op(10, 19, 1, -1);
    do_op(10, 20, 1, -1);
    repeat (4) do_op($urandom_range(0, 127), $urandom_range(0, 127), 1, -1);
  endtask

  task automatic test_mul();
    do_op(120, 99, 2, -1);
    do_op(0, 77, 2, -1);
    repeat (4) do_op($urandom_range(0, 127), $urandom_range(0, 127), 2, -1);
  endtask

  task automatic test_div();
    do_op(99, 7, 3, -1);
    do_op(50, 0, 3, -1);
    do_op(1, 99, 3, -1);
    do_op(127, 1, 3, -1);
    repeat (6) do_op($urandom_range(0, 127), $urandom_range(0, 127), 3, -1);
  endtask

  task automatic test_back_to_back();
    do_op(99, 7, 3, 3);
    do_op(64, 9, 3, 1);
    do_op(8, 30, 1, 1);
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    @(negedge iCLK);
    iSW = {7'd99, 7'd7, 4'b0011};
    iSTART = 1;
    @(posedge iCLK);
    #1 iSTART = 0;
    repeat (4) @(posedge iCLK);
    #2 iRST = 1;
    #1;
    total++; if ({oA, oB, oRESULT, oTYPE, oBUSY, oDONE, oVALID, oDIVZ} !== '0) $display("FAIL reset_mid_div: got %h want 0", {oA, oB, oRESULT, oTYPE, oBUSY, oDONE, oVALID, oDIVZ}); else passed++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge iCLK);
      if (i == 2) iRST = 0;
      if (oDONE) seen = 1;
    end
    total++; if (seen !== 1'b0) $display("FAIL done_after_abort: got %b want 0", seen); else passed++;
    do_op(10, 3, 3, -1);
    total++; if ({oRESULT[13:7], oRESULT[6:0]} !== {7'd3, 7'd1}) $display("FAIL div_10_3: got q=%0d r=%0d want q=3 r=1", oRESULT[13:7], oRESULT[6:0]); else passed++;
  endtask

  task automatic test_random();
    repeat (20) do_op($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3), $urandom_range(0, 8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
